// File: rtl/ercm_mul_arbiter.sv
// rtl/ercm_mul_arbiter.sv - round-robin front end sharing one external 8x8 multiplier core
// Optional error statistics enabled by ERCM_ERR_STAT_EN.
module ercm_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_vld_i,
  output logic [NREQ-1:0]   req_rdy_o,
  input  logic [NREQ*8-1:0] req_a_i,
  input  logic [NREQ*8-1:0] req_b_i,
  input  logic [NREQ*7-1:0] req_mask_i,
  output logic [7:0]        mul_a_o,
  output logic [7:0]        mul_b_o,
  output logic [6:0]        mul_mask_o,
  input  logic [15:0]       mul_p_i,
  output logic              dat_vld_o,
  input  logic              dat_rdy_i,
  output logic [15:0]       dat_o,
  output logic [ID_W-1:0]   dat_id_o,
  output logic              busy_o
`ifdef ERCM_ERR_STAT_EN
  ,
  output logic [15:0]       dat_err_o,
  output logic [23:0]       err_sum_o,
  output logic [15:0]       err_max_o
`endif
);

  logic            r_s1_vld;
  logic            r_s2_vld;
  logic [7:0]      r_s1_a;
  logic [7:0]      r_s1_b;
  logic [6:0]      r_s1_mask;
  logic [ID_W-1:0] r_s1_id;
  logic [ID_W-1:0] r_rr_ptr;
  logic [15:0]     r_dat;
  logic [ID_W-1:0] r_dat_id;

  logic            w_s2_adv;
  logic            w_s1_adv;
  logic            w_s1_free;
  logic            w_found;
  logic [NREQ-1:0] w_grant;
  logic [ID_W-1:0] w_gnt_id;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [7:0]      w_gnt_a;
  logic [7:0]      w_gnt_b;
  logic [6:0]      w_gnt_mask;

  assign w_s2_adv  = !r_s2_vld || dat_rdy_i;
  assign w_s1_adv  = r_s1_vld && w_s2_adv;
  assign w_s1_free = !r_s1_vld || w_s2_adv;

  // Grant is suppressed during the reset cycle so no requester sees a false accept.
  always_comb begin
    int idx;
    idx        = 0;
    w_grant    = '0;
    w_gnt_id   = '0;
    w_found    = 1'b0;
    w_gnt_a    = '0;
    w_gnt_b    = '0;
    w_gnt_mask = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req_vld_i[idx] && w_s1_free && rst_n) begin
        w_found      = 1'b1;
        w_grant[idx] = 1'b1;
        w_gnt_id     = ID_W'(idx);
        w_gnt_a      = req_a_i[8*idx +: 8];
        w_gnt_b      = req_b_i[8*idx +: 8];
        w_gnt_mask   = req_mask_i[7*idx +: 7];
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_id == ID_W'(NREQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s2_vld  <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_mask <= '0;
      r_s1_id   <= '0;
      r_rr_ptr  <= '0;
      r_dat     <= '0;
      r_dat_id  <= '0;
    end else begin
      if (w_s1_free) begin
        r_s1_vld <= w_found;
        if (w_found) begin
          r_s1_a    <= w_gnt_a;
          r_s1_b    <= w_gnt_b;
          r_s1_mask <= w_gnt_mask;
          r_s1_id   <= w_gnt_id;
          r_rr_ptr  <= w_ptr_nxt;
        end
      end
      if (w_s1_adv) begin
        r_s2_vld <= 1'b1;
        r_dat    <= mul_p_i;
        r_dat_id <= r_s1_id;
      end else if (w_s2_adv) begin
        r_s2_vld <= 1'b0;
      end
    end
  end

  assign req_rdy_o  = w_grant;
  assign mul_a_o    = r_s1_a;
  assign mul_b_o    = r_s1_b;
  assign mul_mask_o = r_s1_mask;
  assign dat_vld_o  = r_s2_vld;
  assign dat_o      = r_dat;
  assign dat_id_o   = r_dat_id;
  assign busy_o     = r_s1_vld || r_s2_vld;

`ifdef ERCM_ERR_STAT_EN
  logic [15:0] r_s1_exact;
  logic [15:0] r_err;
  logic [23:0] r_err_sum;
  logic [15:0] r_err_max;
  logic [24:0] w_sum_add;

  assign w_sum_add = {1'b0, r_err_sum} + 25'(r_err);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_exact <= '0;
      r_err      <= '0;
      r_err_sum  <= '0;
      r_err_max  <= '0;
    end else begin
      if (w_found) r_s1_exact <= 16'(w_gnt_a) * 16'(w_gnt_b);
      if (w_s1_adv) r_err <= r_s1_exact - mul_p_i;
      if (r_s2_vld && dat_rdy_i) begin
        r_err_sum <= w_sum_add[24] ? 24'hFFFFFF : w_sum_add[23:0];
        if (r_err > r_err_max) r_err_max <= r_err;
      end
    end
  end

  assign dat_err_o = r_err;
  assign err_sum_o = r_err_sum;
  assign err_max_o = r_err_max;
`endif

endmodule

// File: tb/tb_ercm_mul_arbiter.sv
// tb/tb_ercm_mul_arbiter.sv - scoreboard bench for ercm_mul_arbiter
module tb_ercm_mul_arbiter;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   vld;
  logic [NREQ-1:0]   req_rdy;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ*7-1:0] req_mask;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [6:0]        mul_mask;
  logic [15:0]       mul_p;
  logic              dat_vld;
  logic              dat_rdy;
  logic [15:0]       dat;
  logic [ID_W-1:0]   dat_id;
  logic              busy;
`ifdef ERCM_ERR_STAT_EN
  logic [15:0]       dat_err;
  logic [23:0]       err_sum;
  logic [15:0]       err_max;
`endif

  logic [7:0] a_arr [NREQ];
  logic [7:0] b_arr [NREQ];
  logic [6:0] m_arr [NREQ];
  logic       auto_new = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int gnt_cnt  = 0;
  int pop_cnt  = 0;
  int exp_ptr  = 0;
  logic [NREQ-1:0] gnt_seen = '0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  function automatic logic [15:0] core_model(input logic [7:0] a, input logic [7:0] b);
`ifdef ERCM_ERR_STAT_EN
    if (a == 8'd3 && b == 8'd3) return 16'h0007;
`endif
    return 16'(a) * 16'(b);
  endfunction

  assign mul_p = core_model(mul_a, mul_b);

  always_comb begin
    req_a    = '0;
    req_b    = '0;
    req_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8]    = a_arr[i];
      req_b[8*i +: 8]    = b_arr[i];
      req_mask[7*i +: 7] = m_arr[i];
    end
  end

  ercm_mul_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_vld_i  (vld),
    .req_rdy_o  (req_rdy),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .req_mask_i (req_mask),
    .mul_a_o    (mul_a),
    .mul_b_o    (mul_b),
    .mul_mask_o (mul_mask),
    .mul_p_i    (mul_p),
    .dat_vld_o  (dat_vld),
    .dat_rdy_i  (dat_rdy),
    .dat_o      (dat),
    .dat_id_o   (dat_id),
    .busy_o     (busy)
`ifdef ERCM_ERR_STAT_EN
    ,
    .dat_err_o  (dat_err),
    .err_sum_o  (err_sum),
    .err_max_o  (err_max)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (auto_new) begin
        for (int i = 0; i < NREQ; i++) begin
          if (gnt_seen[i]) begin
            a_arr[i] = 8'($urandom);
            b_arr[i] = 8'($urandom);
            m_arr[i] = 7'($urandom);
          end
        end
      end
    end
  endtask

  // Monitor: predicts the round-robin winner, queues its product, and scores results.
  always @(negedge clk) begin
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] exp_vec;
    logic [31:0]     exp_res;
    int              g;
    if (!rst_n) begin
      check("rdy_in_reset", 32'(req_rdy), 32'd0);
      sb.delete();
      exp_ptr  = 0;
      gnt_seen = '0;
    end else begin
      gnt = req_rdy & vld;
      if (gnt != '0) begin
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && vld[(exp_ptr + k) % NREQ]) g = (exp_ptr + k) % NREQ;
        end
        exp_vec    = '0;
        exp_vec[g] = 1'b1;
        check("arb_grant", 32'(req_rdy), 32'(exp_vec));
        sb.push_back({14'd0, 2'(g), core_model(a_arr[g], b_arr[g])});
        exp_ptr = (g + 1) % NREQ;
        gnt_cnt++;
      end
      gnt_seen = gnt;
      if (dat_vld && dat_rdy) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_res = sb.pop_front();
          check("result", {14'd0, dat_id, dat}, exp_res);
        end
      end
    end
  end

  int g0;
  int p0;
  logic [15:0] hold_dat;
  logic [7:0]  hold_a;

  initial begin
    rst_n   = 1'b0;
    vld     = '1;
    dat_rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 8'($urandom);
      b_arr[i] = 8'($urandom);
      m_arr[i] = 7'($urandom);
    end

    // Reset state
    step();
    @(negedge clk);
    check("rst_dat_vld", 32'(dat_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_dat", 32'(dat), 32'd0);
    check("rst_dat_id", 32'(dat_id), 32'd0);
    step();
    rst_n = 1'b1;

    // Single request
    a_arr[0] = 8'h01;
    b_arr[0] = 8'hC8;
    m_arr[0] = 7'h00;
    vld      = 4'b0001;
    step();
    vld = '0;
    @(negedge clk);
    check("s1_mul_a", 32'(mul_a), 32'h01);
    check("s1_mul_b", 32'(mul_b), 32'hC8);
    check("s1_mul_mask", 32'(mul_mask), 32'h00);
    check("s1_dat_vld", 32'(dat_vld), 32'd0);
    check("s1_busy", 32'(busy), 32'd1);
    step();
    @(negedge clk);
    check("single_vld", 32'(dat_vld), 32'd1);
    check("single_dat", 32'(dat), 32'h00C8);
    check("single_id", 32'(dat_id), 32'd0);

`ifdef ERCM_ERR_STAT_EN
    step();
    a_arr[0] = 8'd3;
    b_arr[0] = 8'd3;
    vld      = 4'b0001;
    step(2);
    vld = '0;
    step();
    @(negedge clk);
    check("err_dat_err", 32'(dat_err), 32'h0002);
    step(3);
    check("err_sum", 32'(err_sum), 32'h000004);
    check("err_max", 32'(err_max), 32'h0002);
`endif

    // Round robin at full throughput
    auto_new = 1'b1;
    vld      = '1;
    step(3);
    g0 = gnt_cnt;
    p0 = pop_cnt;
    step(8);
    check("rr_grants", 32'(gnt_cnt - g0), 32'd8);
    check("rr_results", 32'(pop_cnt - p0), 32'd8);

    // Backpressure from an empty pipeline
    vld = '0;
    step(3);
    dat_rdy = 1'b0;
    vld     = '1;
    g0      = gnt_cnt;
    step(2);
    @(negedge clk);
    hold_dat = dat;
    hold_a   = mul_a;
    step(3);
    check("bp_accepts", 32'(gnt_cnt - g0), 32'd2);
    @(negedge clk);
    check("bp_rdy_low", 32'(req_rdy), 32'd0);
    check("bp_dat_hold", 32'(dat), 32'(hold_dat));
    check("bp_mul_a_hold", 32'(hold_a), 32'(mul_a));
    check("bp_vld", 32'(dat_vld), 32'd1);
    dat_rdy = 1'b1;
    step(6);
    vld = '0;
    step(4);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Reset with both stages full
    vld     = '1;
    dat_rdy = 1'b0;
    step(3);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    vld   = 4'b1010;
    step();
    rst_n   = 1'b1;
    dat_rdy = 1'b1;
    @(negedge clk);
    check("mid_rst_vld", 32'(dat_vld), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_first_gnt", 32'(req_rdy), 32'b0010);
    step(4);

    // Sparse: only requester 2
    vld      = '0;
    auto_new = 1'b0;
    step(3);
    a_arr[2] = 8'hFF;
    b_arr[2] = 8'h00;
    vld      = 4'b0100;
    step(2);
    g0 = gnt_cnt;
    step(6);
    check("sparse_grants", 32'(gnt_cnt - g0), 32'd6);
    @(negedge clk);
    check("sparse_vld", 32'(dat_vld), 32'd1);
    check("sparse_dat", 32'(dat), 32'd0);
    check("sparse_id", 32'(dat_id), 32'd2);

    vld = '0;
    step(4);
    @(negedge clk);
    check("end_sb_empty", 32'(sb.size()), 32'd0);
    check("end_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
